rv64i_control_fsm: RTL and testbench
====================================

# rv64i_control_fsm

Multi-cycle control sequencer for the RV64I core. It fetches each instruction over a request/acknowledge instruction-memory handshake and latches it into the instruction register. It classifies the opcode into the one-hot `Instruction_TYPE` vector that drives the immediate extractor. It then steps the datapath through execute, memory and write-back, raising per-state control strobes, and halts on illegal opcodes or memory timeouts.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 255: maximum wait cycles for a memory acknowledge before halting; legal range 1..255.

Ports:
- `CLK` in 1: the single clock; all state changes on its rising edge.
- `RST_N` in 1: reset, asynchronous, active-low.
- `IMemReq` out 1: instruction fetch request.
- `IMemAck` in 1: fetch acknowledge; `IMemData` is valid in the same cycle.
- `IMemData` in 32: fetched instruction word.
- `Instruction` out 32: latched instruction register.
- `Instruction_TYPE` out 12: one-hot class, registered.
- `BranchTaken` in 1: branch comparator result, valid in EXECUTE.
- `DMemReq` out 1: data memory request.
- `DMemWe` out 1: data memory write enable (store).
- `DMemAck` in 1: data acknowledge.
- `AluSrcA` out 1: 0 selects rs1, 1 selects PC.
- `AluSrcB` out 1: 0 selects rs2, 1 selects immediate `VALUE`.
- `WbSel` out 2: 0 selects ALU result, 1 selects load data, 2 selects PC+4.
- `RegWrite` out 1: register file write strobe.
- `PcWrite` out 1: PC update strobe.
- `PcSel` out 1: 0 selects PC+4, 1 selects the registered ALU target.
- `Retired` out 1: one-cycle pulse per completed instruction.
- `Halted` out 1: sticky halt flag.
- `HaltCause` out 2: 0 none, 1 illegal opcode, 2 memory timeout.

## Operation
`Instruction_TYPE` bit map (exactly one bit set; all-zero means illegal). Classification is made from `opcode = IR[6:0]` and `funct3`:
- Bit 0: OP (0110011).
- Bit 1: OP-32 (0111011).
- Bit 2: LOAD (0000011).
- Bit 3: OP-IMM (0010011), excluding shifts.
- Bit 4: OP-IMM-32 (0011011), excluding shifts.
- Bit 5: JALR (1100111).
- Bit 6: STORE (0100011).
- Bit 7: BRANCH (1100011).
- Bit 8: LUI (0110111).
- Bit 9: AUIPC (0010111).
- Bit 10: JAL (1101111).
- Bit 11: OP-IMM or OP-IMM-32 with funct3 001 or 101 (shift-immediate). Bits 3/4 stay clear in this case.
- MISC-MEM (0001111, FENCE) is retired as a no-op with all type bits 0 and no halt.
- Every other opcode, including SYSTEM, is illegal.

States: FETCH, DECODE, EXECUTE, MEM, WB, HALT.
- FETCH: `IMemReq`=1. On `IMemAck`=1, latch `IMemData` into the IR and go to DECODE.
- DECODE: register `Instruction_TYPE`. Illegal opcode goes to HALT with cause 1; otherwise go to EXECUTE.
- EXECUTE: drive `AluSrcA` and `AluSrcB` per class.
  - Register-register (bits 0-1) selects rs1/rs2; BRANCH selects rs1/rs2 for the compare.
  - LOAD, OP-IMM, shift-immediate, STORE and JALR select rs1/immediate.
  - AUIPC and JAL select PC/immediate; LUI selects immediate.
  - BRANCH: `PcWrite`=1, `PcSel`=`BranchTaken`, `Retired`=1, next state FETCH.
  - LOAD or STORE: go to MEM.
  - All other classes, FENCE included: go to WB.
- MEM: `DMemReq`=1, `DMemWe`=1 for STORE only.
  - On `DMemAck`, a LOAD goes to WB.
  - On `DMemAck`, a STORE pulses `PcWrite` (`PcSel`=0) and `Retired`, then goes to FETCH.
- WB:
  - `RegWrite`=1 for every class except FENCE.
  - `WbSel` is 1 for LOAD, 2 for JAL/JALR, 0 otherwise.
  - `PcWrite`=1, with `PcSel`=1 for JAL/JALR and 0 otherwise.
  - `Retired`=1; next state FETCH.
- HALT: absorbing. Only `RST_N` leaves it.

Timeout:
- An 8-bit wait counter clears on entry to FETCH or MEM and increments each cycle the acknowledge is low.
- When it reaches `MEM_TIMEOUT` with the acknowledge still low, the next state is HALT with cause 2.
- An acknowledge arriving in that same cycle wins.

## Timing
- Reset: state is FETCH. IR, `Instruction_TYPE`, `HaltCause` and the counter are 0.
- All strobes are 0 during reset; `IMemReq` rises on the first cycle after `RST_N` deasserts.
- Strobe outputs are Moore-decoded from the state register and the registered `Instruction_TYPE`. `PcSel` in EXECUTE follows `BranchTaken` combinationally.
- Request is held high until the acknowledge is sampled and drops the next cycle. An acknowledge without a request is ignored.
- Minimum latency with zero-wait acknowledges:
  - BRANCH: 3 cycles.
  - ALU, LUI, AUIPC, JAL, JALR, FENCE: 4 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
- `RST_N` low mid-instruction aborts immediately with no `Retired` pulse. Outputs are 0 asynchronously.
- In HALT every strobe is 0 and `Halted`=1.

## Test plan
- ADDI x1,x0,5 (0x00500093), zero-wait: `Instruction_TYPE`=0x008, `AluSrcB`=1, `RegWrite` and `PcWrite` in cycle 4, `Retired` once.
- SLLI (0x00209093): `Instruction_TYPE`=0x800, not 0x008. LW: 0x004, `DMemAck` delayed 3 cycles, `RegWrite` with `WbSel`=1 in cycle 8.
- BEQ, `BranchTaken`=1 then 0: `PcWrite` in cycle 3 with `PcSel` 1 then 0, `Instruction_TYPE`=0x080, no `RegWrite`.
- JAL: `Instruction_TYPE`=0x400, WB drives `WbSel`=2, `PcSel`=1. FENCE: retires with `RegWrite`=0.
- ECALL (0x00000073): HALT with `HaltCause`=1, no `Retired`, `IMemReq` stays 0 thereafter.
- `MEM_TIMEOUT`=4 with `IMemAck` held 0: HALT with cause 2 after 4 wait cycles. Separately, assert `RST_N` low mid-MEM: all outputs 0 immediately, and fetch restarts after release.

Source files
------------

// File: rtl/rv64i_control_fsm.sv
// Multi-cycle control sequencer for the RV64I core: fetch, decode, execute, memory, write-back.
// Strobes are decoded from the state register and the registered instruction class.
module rv64i_control_fsm #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST_N,
    output logic        IMemReq,
    input  logic        IMemAck,
    input  logic [31:0] IMemData,
    output logic [31:0] Instruction,
    output logic [11:0] Instruction_TYPE,
    input  logic        BranchTaken,
    output logic        DMemReq,
    output logic        DMemWe,
    input  logic        DMemAck,
    output logic        AluSrcA,
    output logic        AluSrcB,
    output logic [1:0]  WbSel,
    output logic        RegWrite,
    output logic        PcWrite,
    output logic        PcSel,
    output logic        Retired,
    output logic        Halted,
    output logic [1:0]  HaltCause
);

    typedef enum logic [2:0] {
        StFetch, StDecode, StExecute, StMem, StWb, StHalt
    } state_e;

    localparam int TyOp = 0, TyOp32 = 1, TyLoad = 2, TyOpImm = 3, TyOpImm32 = 4, TyJalr = 5;
    localparam int TyStore = 6, TyBranch = 7, TyLui = 8, TyAuipc = 9, TyJal = 10, TyShImm = 11;
    localparam logic [7:0] TimeoutCnt = MEM_TIMEOUT[7:0];

    state_e      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic [11:0] type_q, type_d, type_dec;
    logic [1:0]  cause_q, cause_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        is_fence, legal, is_shift, wait_ack;

    always_comb begin
        type_dec = '0;
        is_fence = 1'b0;
        is_shift = (ir_q[14:12] == 3'b001) || (ir_q[14:12] == 3'b101);
        case (ir_q[6:0])
            7'b0110011: type_dec[TyOp]   = 1'b1;
            7'b0111011: type_dec[TyOp32] = 1'b1;
            7'b0000011: type_dec[TyLoad] = 1'b1;
            7'b0010011: begin
                if (is_shift) type_dec[TyShImm] = 1'b1;
                else          type_dec[TyOpImm] = 1'b1;
            end
            7'b0011011: begin
                if (is_shift) type_dec[TyShImm]  = 1'b1;
                else          type_dec[TyOpImm32] = 1'b1;
            end
            7'b1100111: type_dec[TyJalr]   = 1'b1;
            7'b0100011: type_dec[TyStore]  = 1'b1;
            7'b1100011: type_dec[TyBranch] = 1'b1;
            7'b0110111: type_dec[TyLui]    = 1'b1;
            7'b0010111: type_dec[TyAuipc]  = 1'b1;
            7'b1101111: type_dec[TyJal]    = 1'b1;
            7'b0001111: is_fence = 1'b1;
            default: ;
        endcase
        legal = (|type_dec) || is_fence;
    end

    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        type_d   = type_q;
        cause_d  = cause_q;
        cnt_d    = cnt_q;
        IMemReq  = 1'b0;
        DMemReq  = 1'b0;
        DMemWe   = 1'b0;
        AluSrcA  = 1'b0;
        AluSrcB  = 1'b0;
        WbSel    = 2'd0;
        RegWrite = 1'b0;
        PcWrite  = 1'b0;
        PcSel    = 1'b0;
        Retired  = 1'b0;
        wait_ack = (state_q == StFetch) ? IMemAck : DMemAck;

        case (state_q)
            StFetch: begin
                // Gated by reset so the request stays low while RST_N is asserted.
                IMemReq = RST_N;
                if (IMemAck) begin
                    ir_d    = IMemData;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                type_d = type_dec;
                if (!legal) begin
                    cause_d = 2'd1;
                    state_d = StHalt;
                end else begin
                    state_d = StExecute;
                end
            end
            StExecute: begin
                AluSrcA = type_q[TyAuipc] | type_q[TyJal];
                AluSrcB = type_q[TyLoad] | type_q[TyOpImm] | type_q[TyOpImm32] | type_q[TyShImm]
                        | type_q[TyStore] | type_q[TyJalr] | type_q[TyAuipc] | type_q[TyJal]
                        | type_q[TyLui];
                if (type_q[TyBranch]) begin
                    PcWrite = 1'b1;
                    PcSel   = BranchTaken;
                    Retired = 1'b1;
                    state_d = StFetch;
                end else if (type_q[TyLoad] || type_q[TyStore]) begin
                    state_d = StMem;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                DMemReq = 1'b1;
                DMemWe  = type_q[TyStore];
                if (DMemAck) begin
                    if (type_q[TyStore]) begin
                        PcWrite = 1'b1;
                        Retired = 1'b1;
                        state_d = StFetch;
                    end else begin
                        state_d = StWb;
                    end
                end
            end
            StWb: begin
                RegWrite = |type_q;
                WbSel    = type_q[TyLoad] ? 2'd1 :
                           (type_q[TyJal] | type_q[TyJalr]) ? 2'd2 : 2'd0;
                PcWrite  = 1'b1;
                PcSel    = type_q[TyJal] | type_q[TyJalr];
                Retired  = 1'b1;
                state_d  = StFetch;
            end
            StHalt: ;
            default: state_d = StHalt;
        endcase

        // Acknowledge arriving in the timeout cycle takes priority over the halt.
        if ((state_q == StFetch || state_q == StMem) && !wait_ack) begin
            if (cnt_q == TimeoutCnt) begin
                cause_d = 2'd2;
                state_d = StHalt;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
        if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StFetch;
            ir_q    <= '0;
            type_q  <= '0;
            cause_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            type_q  <= type_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Instruction      = ir_q;
    assign Instruction_TYPE = type_q;
    assign Halted           = (state_q == StHalt);
    assign HaltCause        = cause_q;

endmodule

// File: tb/tb_rv64i_control_fsm.sv
// Directed bench for rv64i_control_fsm: one instruction per class, halts, timeout and mid-MEM reset.
module tb_rv64i_control_fsm;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        IMemReq, IMemAck;
    logic [31:0] IMemData, Instruction;
    logic [11:0] Instruction_TYPE;
    logic        BranchTaken, DMemReq, DMemWe, DMemAck;
    logic        AluSrcA, AluSrcB, RegWrite, PcWrite, PcSel, Retired, Halted;
    logic [1:0]  WbSel, HaltCause;

    int checks = 0;
    int errors = 0;

    rv64i_control_fsm #(.MEM_TIMEOUT(4)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .IMemReq(IMemReq), .IMemAck(IMemAck), .IMemData(IMemData),
        .Instruction(Instruction), .Instruction_TYPE(Instruction_TYPE),
        .BranchTaken(BranchTaken),
        .DMemReq(DMemReq), .DMemWe(DMemWe), .DMemAck(DMemAck),
        .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .WbSel(WbSel),
        .RegWrite(RegWrite), .PcWrite(PcWrite), .PcSel(PcSel),
        .Retired(Retired), .Halted(Halted), .HaltCause(HaltCause)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Zero-wait fetch: returns in the DECODE cycle.
    task automatic fetch(input string tag, input logic [31:0] word);
        IMemData = word;
        IMemAck  = 1'b1;
        #1;
        chk({tag, "_req"}, IMemReq, 1);
        tick();
        IMemAck  = 1'b0;
        IMemData = '0;
        #1;
        chk({tag, "_ir"}, Instruction, word);
        chk({tag, "_req_drop"}, IMemReq, 0);
    endtask

    initial begin
        RST_N = 1'b0; IMemAck = 1'b0; IMemData = '0; BranchTaken = 1'b0; DMemAck = 1'b0;
        #1;
        chk("rst_req", IMemReq, 0);
        chk("rst_ir", Instruction, 0);
        chk("rst_type", Instruction_TYPE, 0);
        chk("rst_cause", HaltCause, 0);
        chk("rst_halted", Halted, 0);
        tick(); tick();
        RST_N = 1'b1;
        #1;
        chk("rel_req", IMemReq, 1);

        // ADDI x1,x0,5
        fetch("addi", 32'h0050_0093);
        tick();
        chk("addi_type", Instruction_TYPE, 12'h008);
        chk("addi_srcb", AluSrcB, 1);
        chk("addi_srca", AluSrcA, 0);
        chk("addi_ex_ret", Retired, 0);
        tick();
        chk("addi_regw", RegWrite, 1);
        chk("addi_pcw", PcWrite, 1);
        chk("addi_pcsel", PcSel, 0);
        chk("addi_wbsel", WbSel, 0);
        chk("addi_ret", Retired, 1);
        tick();
        chk("addi_ret_once", Retired, 0);
        chk("addi_next_req", IMemReq, 1);

        // SLLI classified as shift-immediate
        fetch("slli", 32'h0020_9093);
        tick();
        chk("slli_type", Instruction_TYPE, 12'h800);
        chk("slli_srcb", AluSrcB, 1);
        tick();
        chk("slli_regw", RegWrite, 1);

        // LW with DMemAck delayed three cycles
        tick();
        fetch("lw", 32'h0000_A103);
        tick();
        chk("lw_type", Instruction_TYPE, 12'h004);
        chk("lw_srcb", AluSrcB, 1);
        tick();
        chk("lw_dreq", DMemReq, 1);
        chk("lw_dwe", DMemWe, 0);
        tick(); tick(); tick();
        DMemAck = 1'b1;
        #1;
        chk("lw_ack_dreq", DMemReq, 1);
        chk("lw_ack_ret", Retired, 0);
        tick();
        DMemAck = 1'b0;
        #1;
        chk("lw_regw", RegWrite, 1);
        chk("lw_wbsel", WbSel, 1);
        chk("lw_ret", Retired, 1);
        tick();

        // BEQ taken, then not taken
        BranchTaken = 1'b1;
        fetch("beq_t", 32'h0000_0463);
        tick();
        chk("beq_t_type", Instruction_TYPE, 12'h080);
        chk("beq_t_pcw", PcWrite, 1);
        chk("beq_t_pcsel", PcSel, 1);
        chk("beq_t_ret", Retired, 1);
        chk("beq_t_regw", RegWrite, 0);
        chk("beq_t_srcb", AluSrcB, 0);
        tick();
        chk("beq_t_back", IMemReq, 1);
        BranchTaken = 1'b0;
        fetch("beq_n", 32'h0000_0463);
        tick();
        chk("beq_n_pcw", PcWrite, 1);
        chk("beq_n_pcsel", PcSel, 0);
        chk("beq_n_regw", RegWrite, 0);
        tick();

        // JAL x1,8
        fetch("jal", 32'h0080_00EF);
        tick();
        chk("jal_type", Instruction_TYPE, 12'h400);
        chk("jal_srca", AluSrcA, 1);
        chk("jal_srcb", AluSrcB, 1);
        tick();
        chk("jal_wbsel", WbSel, 2);
        chk("jal_pcsel", PcSel, 1);
        chk("jal_regw", RegWrite, 1);
        tick();

        // SW x2,4(x1), zero-wait
        fetch("sw", 32'h0020_A223);
        tick();
        chk("sw_type", Instruction_TYPE, 12'h040);
        tick();
        DMemAck = 1'b1;
        #1;
        chk("sw_dreq", DMemReq, 1);
        chk("sw_dwe", DMemWe, 1);
        chk("sw_pcw", PcWrite, 1);
        chk("sw_pcsel", PcSel, 0);
        chk("sw_ret", Retired, 1);
        tick();
        DMemAck = 1'b0;
        #1;
        chk("sw_back", IMemReq, 1);

        // FENCE retires without a register write
        fetch("fence", 32'h0FF0_000F);
        tick();
        chk("fence_type", Instruction_TYPE, 0);
        chk("fence_halted", Halted, 0);
        tick();
        chk("fence_regw", RegWrite, 0);
        chk("fence_pcw", PcWrite, 1);
        chk("fence_ret", Retired, 1);
        tick();

        // ECALL is illegal
        fetch("ecall", 32'h0000_0073);
        tick();
        chk("ecall_halted", Halted, 1);
        chk("ecall_cause", HaltCause, 1);
        chk("ecall_ret", Retired, 0);
        chk("ecall_req", IMemReq, 0);
        IMemAck = 1'b1;
        tick(); tick();
        chk("ecall_stuck_req", IMemReq, 0);
        chk("ecall_stuck_halt", Halted, 1);
        IMemAck = 1'b0;

        // Reset out of HALT, then abort mid-MEM
        RST_N = 1'b0;
        #1;
        chk("halt_rst_halted", Halted, 0);
        chk("halt_rst_cause", HaltCause, 0);
        tick();
        RST_N = 1'b1;
        #1;
        fetch("lw2", 32'h0000_A103);
        tick(); tick();
        chk("mid_dreq", DMemReq, 1);
        RST_N = 1'b0;
        #1;
        chk("mid_rst_dreq", DMemReq, 0);
        chk("mid_rst_req", IMemReq, 0);
        chk("mid_rst_ret", Retired, 0);
        chk("mid_rst_ir", Instruction, 0);
        chk("mid_rst_type", Instruction_TYPE, 0);
        tick();
        RST_N = 1'b1;
        #1;
        chk("mid_restart_req", IMemReq, 1);

        // Fetch timeout with MEM_TIMEOUT=4: counter reaches 4 in the fifth FETCH cycle
        tick(); tick(); tick(); tick();
        chk("to_still_req", IMemReq, 1);
        chk("to_not_halted", Halted, 0);
        tick();
        chk("to_halted", Halted, 1);
        chk("to_cause", HaltCause, 2);
        chk("to_req", IMemReq, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
